// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Optional saturating error counter enabled by PARITY_FRAME_RX_ERR_CNT_EN.
module parity_frame_rx #(
  parameter int DATA_W     = 4,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par_err,
  output logic              out_frame_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              busy
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
  ,
  input  logic              err_cnt_clr,
  output logic [7:0]        err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [3:0] LAST = 4'(DATA_W - 1);
  localparam logic       ODD  = (ODD_PARITY != 0);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_nxt;
  logic              p;
  logic              p_nxt;
  logic              done;
  logic              load;
  logic              par_err;
  logic              frame_err;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    p_nxt     = p;
    done      = 1'b0;
    if (bit_en) begin
      unique case (state)
        IDLE: begin
          if (!rx_bit) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
          end
        end
        DATA: begin
          sh_nxt             = sh >> 1;
          sh_nxt[DATA_W-1]   = rx_bit;
          cnt_nxt            = cnt + 4'd1;
          if (cnt == LAST)
            state_nxt = PARITY;
        end
        PARITY: begin
          p_nxt     = rx_bit;
          state_nxt = STOP;
        end
        STOP: begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign par_err   = p ^ (^sh) ^ ODD;
  assign frame_err = ~rx_bit;
  // A completed frame lands only if the buffer is free or drains this edge
  assign load      = done && (!out_valid || out_ready);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      sh            <= '0;
      p             <= 1'b0;
      out_data      <= '0;
      out_par_err   <= 1'b0;
      out_frame_err <= 1'b0;
      out_valid     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sh      <= sh_nxt;
      p       <= p_nxt;
      overrun <= done && out_valid && !out_ready;
      if (load) begin
        out_data      <= sh;
        out_par_err   <= par_err;
        out_frame_err <= frame_err;
        out_valid     <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_FRAME_RX_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || err_cnt_clr) begin
      err_cnt <= '0;
    end else if (load && (par_err || frame_err) && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Serial receive stage that pairs with the combinational nibble parity generator; it consumes the serial frames whose parity bit that generator produces.
- Deframes start / DATA_W data bits / parity / stop and checks the parity bit against the XOR reduction of the received data.
- Holds each checked word in a one-entry output buffer with a valid/ready handshake.
- Frame, parity and overrun errors are reported alongside the data.

Parameters:
- DATA_W, default 4: data bits per frame, LSB first; legal range 1..16.
- ODD_PARITY, default 0: 0 = even parity (parity bit = ^data); 1 = odd parity (parity bit = ~^data).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- bit_en  input  1  bit-time strobe; rx_bit is sampled only in cycles where bit_en=1.
- rx_bit  input  1  serial line, idle high.
- out_data  output  DATA_W  received word.
- out_par_err  output  1  parity mismatch for out_data.
- out_frame_err  output  1  stop bit was 0 for out_data.
- out_valid  output  1  buffer holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid=1 and out_ready=1.
- overrun  output  1  one-cycle pulse: a completed frame was dropped.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: clk rising edge with rst_n=0. It forces the FSM to IDLE, clears the bit counter and shift register, and sets out_data=0, out_par_err=0, out_frame_err=0, out_valid=0, overrun=0, busy=0. This applies mid-frame too: a partial frame is discarded and nothing is output.
- Cycles with bit_en=0 never change FSM state, the counter or the shift register.
- IDLE: bit_en=1 with rx_bit=0 (start bit) goes to DATA with cnt=0. With rx_bit=1 the FSM stays in IDLE.
- DATA: each bit_en shifts rx_bit into the shift register, LSB first, and increments cnt. When cnt reaches DATA_W-1 on a strobe, that bit is stored and the FSM goes to PARITY.
- PARITY: on bit_en, rx_bit is captured as the received parity bit p and the FSM goes to STOP.
- STOP: on bit_en the frame completes.
  - par_err = p XOR (^data) XOR ODD_PARITY.
  - frame_err = ~rx_bit.
  - The FSM returns to IDLE.
  - The start bit is never re-checked.
- Frame length is DATA_W+3 strobes. Output latency: out_valid rises on the clock edge of the stop-bit strobe.
- Output buffer, on the frame-completion edge:
  - If out_valid=0, or out_valid=1 and out_ready=1 (accept in the same cycle): load data and flags, out_valid=1.
  - If out_valid=1 and out_ready=0: the new frame is dropped, the buffer is unchanged, and overrun=1 for one cycle.
- Accept without completion: out_valid=1 and out_ready=1 clears out_valid next edge. out_data and the flags hold their last value.
- While out_valid=1, out_data and the flags are stable until accepted.
- A frame with errors is still delivered. Consumers discard it based on the flags.
- busy=1 in DATA, PARITY and STOP.

Optional Feature:
- Macro PARITY_FRAME_RX_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [7:0]: a saturating count of frames delivered with out_par_err or out_frame_err set.
  - It increments on the buffer-load edge and saturates at 255.
  - It is cleared by reset and by input err_cnt_clr (1 bit). The clear wins over a simultaneous increment.
- When not defined: neither port exists and there is no counter logic; behaviour is otherwise identical.

Test Plan:
- Default params, bit_en every cycle, serial 0,1,0,1,1,0,1 (start, data LSB-first 1,0,1,1 = 4'hD, parity 0 (^D=1), stop 1), out_ready=1 → out_data=4'hD, out_par_err=1, out_frame_err=0, out_valid high exactly 1 cycle, on the edge of strobe 7.
- Same frame with parity bit 1 → out_data=4'hD, par_err=0. Repeat with ODD_PARITY=1, parity bit 0 → par_err=0.
- Frame 4'h3 with correct parity and stop bit 0 → out_data=4'h3, frame_err=1, par_err=0.
- out_ready=0: send 4'hA then 4'h5 → second frame completes, overrun pulses 1 cycle, out_data stays 4'hA. Raise out_ready → 4'hA accepted, out_valid=0.
- rst_n=0 for one edge after 2 data bits, then a full 4'h6 frame → no output from the partial frame, then out_data=4'h6. bit_en every 3rd cycle gives the same results with latency scaled.
- With PARITY_FRAME_RX_ERR_CNT_EN: 3 bad-parity frames → err_cnt=3. err_cnt_clr on the same edge as a 4th bad frame loads → err_cnt=0. 300 bad frames → err_cnt=255.
